sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation search engine: drives a trial operand to an external magnitude comparator and consumes its single-bit "trial <= target" flag.
- Performs a binary search to recover the largest trial value not exceeding the comparator's other operand.
- Sits alongside the relational/equality comparator logic: that logic produces the flags, this block generates the operand and consumes the flags.

Parameters:
- WIDTH, 4, operand width in bits (>= 2).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new search; accepted only in IDLE.
- cmp_le  input  1  combinational comparator result for the current trial: 1 when trial <= target.
- trial  output  WIDTH  operand driven to the comparator.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when the result is written.
- result  output  WIDTH  last completed search result; held until the next completion.
- result_valid  output  1  high when result holds a completed search.

Behaviour:
- Reset (async, active-high): state=IDLE, trial=0, busy=0, done=0, result=0, result_valid=0, bit pointer=0.
- States: IDLE, TEST, DONE.
- IDLE:
  - start=1 -> trial <= 1<<(WIDTH-1), pointer k <= WIDTH-1, busy <= 1, result_valid <= 0, go to TEST.
  - start=0 -> hold.
- TEST (bit k), one cycle per bit, cmp_le sampled at the clock edge:
  - cmp_le=0 -> clear trial[k]; cmp_le=1 -> keep trial[k].
  - If k>0: set trial[k-1], k <= k-1, stay in TEST.
  - If k==0: result <= final trial (bit 0 resolved), trial <= same value, busy <= 0, done <= 1, result_valid <= 1, go to DONE.
- DONE: done pulse visible for exactly this one cycle; unconditionally return to IDLE.
- Latency: start accepted at edge N; busy high from N+1; WIDTH TEST cycles; done high for the cycle after edge N+WIDTH; result stable from that cycle onward.
- start is ignored in TEST and DONE; no queuing. A new search can be accepted in the first IDLE cycle after DONE.
- trial is registered and stable for a full cycle before each sample; cmp_le must settle within one cycle.
- Results for target 0 and target 2^WIDTH-1 need no special case: the search yields 0 and all-ones respectively.
- Reset mid-search: immediate return to the reset values; the previous result is lost.
- result_valid is cleared on every accepted start and set with done.

Optional Feature:
- Macro SAR_EARLY_EQ_EN.
- Defined:
  - Adds input cmp_eq (1 bit, trial == target).
  - In TEST, cmp_eq=1 ends the search at that edge: result <= trial unchanged, done/result_valid set, go to DONE. Remaining bits stay 0.
  - cmp_eq takes priority over the k==0 path.
- Not defined: cmp_eq port absent; every search takes exactly WIDTH TEST cycles.

Decomposition:
- Package sar_pkg:
  - state enum {IDLE, TEST, DONE}.
  - SAR_WIDTH_DEF=4.
  - Pointer width function clog2(WIDTH).
- No sub-module: a single FSM plus datapath.
- The bench instantiates a behavioural comparator (trial <= target, trial == target) as the responder.

Test Plan:
- WIDTH=4, target=9, pulse start -> trial sequence 8,12,10,9; cmp_le sequence 1,0,0,1; done one cycle after the 4th TEST; result=9, result_valid=1.
- target=0 -> trials 8,4,2,1 -> result=0; target=15 -> trials 8,12,14,15 -> result=15; each takes 4 TEST cycles.
- start held high throughout a search with target=5 -> exactly one search; result=5; next search begins in the first IDLE cycle after DONE; result_valid drops at that accept.
- rst asserted during the 2nd TEST cycle -> outputs return to reset values without waiting for a clock; a subsequent start with target=3 yields result=3.
- SAR_EARLY_EQ_EN defined, target=8 -> done after 1 TEST cycle, result=8; target=12 -> done after 2 TEST cycles, result=12; macro undefined, target=8 -> 4 TEST cycles, result=8.
- Back-to-back searches with targets 6 then 10 -> results 6 then 10; result holds 6 until the second done.

Source files
------------

// File: rtl/sar_pkg.sv
// ============================================================================
// Module   : sar_pkg
// Brief    : Shared types, defaults and helpers for the SAR search engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_t;

    // Width of the bit pointer; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sar_search_if.sv
// ============================================================================
// Module   : sar_search_if
// Brief    : Comparator-side handshake of the SAR search engine.
//            SAR_EARLY_EQ_EN adds the cmp_eq flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_le;
`ifdef SAR_EARLY_EQ_EN
    logic             cmp_eq;
`endif
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    // The search engine is the master; the comparator/requester side is the slave.
    modport master (
        input  start,
        input  cmp_le,
`ifdef SAR_EARLY_EQ_EN
        input  cmp_eq,
`endif
        output trial,
        output busy,
        output done,
        output result,
        output result_valid
    );

    modport slave (
        output start,
        output cmp_le,
`ifdef SAR_EARLY_EQ_EN
        output cmp_eq,
`endif
        input  trial,
        input  busy,
        input  done,
        input  result,
        input  result_valid
    );

endinterface

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// Module   : sar_search
// Brief    : Successive-approximation search over an external comparator.
//            Optional macro SAR_EARLY_EQ_EN ends the search on cmp_eq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sar_search_if.master bus
);

    localparam int               c_ptr_w      = clog2(WIDTH);
    localparam logic [c_ptr_w-1:0] c_ptr_init = c_ptr_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_trial_init = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [WIDTH-1:0]   r_trial;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;

    logic [WIDTH-1:0]   w_resolved;
    logic [WIDTH-1:0]   w_next;

    // w_resolved settles the bit under test; w_next also raises the next bit.
    always_comb begin
        w_resolved = r_trial;
        if (!bus.cmp_le) w_resolved[r_ptr] = 1'b0;
        w_next = w_resolved;
        if (r_ptr != '0) w_next[r_ptr - 1'b1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_trial  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_trial <= c_trial_init;
                        r_ptr   <= c_ptr_init;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= TEST;
                    end
                end
                TEST: begin
`ifdef SAR_EARLY_EQ_EN
                    if (bus.cmp_eq) begin
                        r_result <= r_trial;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else
`endif
                    if (r_ptr == '0) begin
                        r_result <= w_resolved;
                        r_trial  <= w_resolved;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_trial <= w_next;
                        r_ptr   <= r_ptr - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.trial        = r_trial;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// ============================================================================
// Module   : tb_sar_search
// Brief    : Self-checking bench for sar_search with a behavioural comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_search;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0]        target;
        logic [3:0][W-1:0]   trials;
        int                  cycles;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] target;
    logic [W-1:0] prev_result;
    logic [W-1:0] sb_q[$];
    int           errors;
    int           checks;
    vec_t         tbl[9];

    sar_search_if #(.WIDTH(W)) bus();

    sar_search #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.cmp_le = (bus.trial <= target);
`ifdef SAR_EARLY_EQ_EN
    assign bus.cmp_eq = (bus.trial == target);
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(bus.busy || bus.done), 0);
    endtask

    // Runs one search; with hold the start line stays high afterwards.
    task automatic run_search(input int idx, input bit hold);
        int  cyc;
        bit  got_done;
        logic [W-1:0] exp_r;
        target = tbl[idx].target;
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        sb_q.push_back(tbl[idx].target);
        cyc = 0;
        got_done = 1'b0;
        for (int t = 0; t < 20 && !got_done; t++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.done) begin
                got_done = 1'b1;
            end else if (bus.busy) begin
                if (cyc < 4) chk($sformatf("trial[%0d] t=%0d", cyc, target),
                                 int'(bus.trial), int'(tbl[idx].trials[cyc]));
                if (cyc == 0) chk("valid_cleared", int'(bus.result_valid), 0);
                chk("result_held", int'(bus.result), int'(prev_result));
                cyc++;
            end
        end
        if (!got_done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        exp_r = sb_q.pop_front();
        chk($sformatf("result t=%0d", target), int'(bus.result), int'(exp_r));
        chk("result_valid", int'(bus.result_valid), 1);
        chk($sformatf("test_cycles t=%0d", target), cyc, tbl[idx].cycles);
        chk("busy_at_done", int'(bus.busy), 0);
        prev_result = exp_r;
        @(negedge clk);
        chk("done_one_cycle", int'(bus.done), 0);
        chk("idle_after_done", int'(bus.busy), 0);
        chk("result_stable", int'(bus.result), int'(exp_r));
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        prev_result = '0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        target      = '0;

        // target, trial sequence, TEST cycles (early-eq build shortens some)
`ifdef SAR_EARLY_EQ_EN
        tbl[0] = '{4'd9,  {4'd9, 4'd10, 4'd12, 4'd8}, 4};
        tbl[3] = '{4'd8,  {4'd9, 4'd10, 4'd12, 4'd8}, 1};
        tbl[4] = '{4'd12, {4'd13, 4'd14, 4'd12, 4'd8}, 2};
        tbl[5] = '{4'd6,  {4'd7, 4'd6, 4'd4, 4'd8}, 3};
        tbl[6] = '{4'd10, {4'd11, 4'd10, 4'd12, 4'd8}, 3};
`else
        tbl[0] = '{4'd9,  {4'd9, 4'd10, 4'd12, 4'd8}, 4};
        tbl[3] = '{4'd8,  {4'd9, 4'd10, 4'd12, 4'd8}, 4};
        tbl[4] = '{4'd12, {4'd13, 4'd14, 4'd12, 4'd8}, 4};
        tbl[5] = '{4'd6,  {4'd7, 4'd6, 4'd4, 4'd8}, 4};
        tbl[6] = '{4'd10, {4'd11, 4'd10, 4'd12, 4'd8}, 4};
`endif
        tbl[1] = '{4'd0,  {4'd1, 4'd2, 4'd4, 4'd8}, 4};
        tbl[2] = '{4'd15, {4'd15, 4'd14, 4'd12, 4'd8}, 4};
        tbl[7] = '{4'd5,  {4'd5, 4'd6, 4'd4, 4'd8}, 4};
        tbl[8] = '{4'd3,  {4'd3, 4'd2, 4'd4, 4'd8}, 4};

        repeat (2) @(negedge clk);
        chk("rst_trial", int'(bus.trial), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_valid", int'(bus.result_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven searches, including back-to-back 6 then 10.
        for (int i = 0; i < 7; i++) run_search(i, 1'b0);

        // start held high: one search, then re-accept on the first IDLE cycle.
        run_search(7, 1'b1);
        @(negedge clk);
        chk("hold_reaccept_busy", int'(bus.busy), 1);
        chk("hold_reaccept_valid", int'(bus.result_valid), 0);
        bus.start = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.done && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("hold_second_done", int'(bus.done), 1);
            chk("hold_second_result", int'(bus.result), 5);
        end

        // Asynchronous reset in the 2nd TEST cycle.
        target = 4'd9;
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_trial", int'(bus.trial), 12);
        rst = 1'b1;
        #1;
        chk("arst_trial", int'(bus.trial), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_result", int'(bus.result), 0);
        chk("arst_valid", int'(bus.result_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        prev_result = '0;
        run_search(8, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
